// File: rtl/lcd_hex_writer.sv
// rtl/lcd_hex_writer.sv - HD44780-style writer: clear, home, N hex digits, space, OK/ER tag.
module lcd_hex_writer #(
  parameter int NIBBLES           = 8,
  parameter int MSB_FIRST         = 1,
  parameter int EN_HIGH_CYCLES    = 12,
  parameter int CHAR_WAIT_CYCLES  = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [4*NIBBLES-1:0]   i_value,
  input  logic                   i_status,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_lcd_rs,
  output logic                   o_lcd_rw,
  output logic                   o_lcd_en,
  output logic [7:0]             o_lcd_data
);

  localparam int LAST_IDX = NIBBLES + 4;
  localparam int MAX_WAIT_A = (CLEAR_WAIT_CYCLES > CHAR_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : CHAR_WAIT_CYCLES;
  localparam int MAX_WAIT   = (MAX_WAIT_A > EN_HIGH_CYCLES) ? MAX_WAIT_A : EN_HIGH_CYCLES;
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int IW = $clog2(LAST_IDX + 1);

  localparam logic [CW-1:0] EN_LOAD = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_W = CW'(CLEAR_WAIT_CYCLES);
  localparam logic [CW-1:0] CHAR_W  = CW'(CHAR_WAIT_CYCLES);
  localparam logic [IW-1:0] LAST_I  = IW'(LAST_IDX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_DONE
  } state_t;

  state_t               r_state, w_next_state;
  logic [CW-1:0]        r_cnt, w_next_cnt, w_wait_len;
  logic [IW-1:0]        r_idx, w_next_idx;
  logic [4*NIBBLES-1:0] r_value, w_src_value;
  logic                 r_status, w_src_status;
  logic                 w_capture, w_advance;
  logic                 r_busy, r_done, r_rs, r_en;
  logic [7:0]           r_data;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Returns {rs, byte} for write slot idx of the fixed write list.
  function automatic logic [8:0] write_entry(input logic [IW-1:0] idx,
                                             input logic [4*NIBBLES-1:0] val,
                                             input logic status);
    int i = int'(idx);
    int k;
    int j;
    logic [8:0] e;
    e = 9'h120;
    if (i == 0) begin
      e = 9'h001;
    end else if (i == 1) begin
      e = 9'h080;
    end else if (i <= NIBBLES + 1) begin
      k = i - 2;
      j = (MSB_FIRST != 0) ? (NIBBLES - 1 - k) : k;
      e = {1'b1, hex_char(val[4*j +: 4])};
    end else if (i == NIBBLES + 2) begin
      e = 9'h120;
    end else if (i == NIBBLES + 3) begin
      e = {1'b1, status ? 8'h45 : 8'h4F};
    end else begin
      e = {1'b1, status ? 8'h52 : 8'h4B};
    end
    return e;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_idx   = r_idx;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_wait_len   = (r_idx == '0) ? CLEAR_W : CHAR_W;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_capture    = 1'b1;
          w_next_idx   = '0;
          w_next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next_state = S_PULSE;
        w_next_cnt   = EN_LOAD;
      end
      S_PULSE: begin
        if (r_cnt == '0) w_next_state = S_HOLD;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      S_HOLD: begin
        // A zero settle count goes straight to the next write.
        if (w_wait_len == '0) begin
          w_advance = 1'b1;
        end else begin
          w_next_state = S_WAIT;
          w_next_cnt   = w_wait_len - 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_advance  = 1'b1;
        else             w_next_cnt = r_cnt - 1'b1;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_advance) begin
      if (r_idx == LAST_I) begin
        w_next_state = S_DONE;
      end else begin
        w_next_idx   = r_idx + 1'b1;
        w_next_state = S_SETUP;
      end
    end
  end

  assign w_src_value  = w_capture ? i_value  : r_value;
  assign w_src_status = w_capture ? i_status : r_status;

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_value  <= '0;
      r_status <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rs     <= 1'b0;
      r_en     <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_idx   <= w_next_idx;
      if (w_capture) begin
        r_value  <= i_value;
        r_status <= i_status;
      end
      r_busy <= (w_next_state == S_SETUP) || (w_next_state == S_PULSE) ||
                (w_next_state == S_HOLD)  || (w_next_state == S_WAIT);
      r_done <= (w_next_state == S_DONE);
      r_en   <= (w_next_state == S_PULSE);
      if (w_next_state == S_SETUP) begin
        {r_rs, r_data} <= write_entry(w_next_idx, w_src_value, w_src_status);
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_data = r_data;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// tb/tb_lcd_hex_writer.sv - directed bench for lcd_hex_writer in three configurations.
module tb_lcd_hex_writer;

  logic        clk;
  logic        rst_n;
  logic        start  [3];
  logic [31:0] value  [2];
  logic [3:0]  value_one;
  logic        status [3];
  logic        busy   [3];
  logic        done   [3];
  logic        rs     [3];
  logic        rw     [3];
  logic        en     [3];
  logic [7:0]  data   [3];

  int n_checks;
  int n_fail;

  logic [8:0] ev       [3][256];
  int         ev_n     [3];
  int         busy_cnt [3];
  int         done_cnt [3];
  int         done_bad [3];
  int         unstable [3];
  logic       prev_en  [3];
  logic       prev_busy[3];
  logic [8:0] prev_bus [3];

  logic [8:0] exp_msb [16] = '{9'h001, 9'h080, 9'h131, 9'h132, 9'h133, 9'h134, 9'h141, 9'h142,
                               9'h143, 9'h144, 9'h120, 9'h14F, 9'h14B, 9'h000, 9'h000, 9'h000};
  logic [8:0] exp_lsb [16] = '{9'h001, 9'h080, 9'h146, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130,
                               9'h130, 9'h130, 9'h120, 9'h145, 9'h152, 9'h000, 9'h000, 9'h000};
  logic [8:0] exp_one [16] = '{9'h001, 9'h080, 9'h139, 9'h120, 9'h14F, 9'h14B, 9'h000, 9'h000,
                               9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  logic [8:0] exp_b2b [16] = '{9'h001, 9'h080, 9'h130, 9'h130, 9'h143, 9'h130, 9'h146, 9'h146,
                               9'h145, 9'h145, 9'h120, 9'h145, 9'h152, 9'h000, 9'h000, 9'h000};

  lcd_hex_writer #(.NIBBLES(8), .MSB_FIRST(1), .EN_HIGH_CYCLES(2),
                   .CHAR_WAIT_CYCLES(3), .CLEAR_WAIT_CYCLES(5)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_value(value[0]), .i_status(status[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_lcd_rs(rs[0]), .o_lcd_rw(rw[0]),
    .o_lcd_en(en[0]), .o_lcd_data(data[0]));

  lcd_hex_writer #(.NIBBLES(8), .MSB_FIRST(0), .EN_HIGH_CYCLES(2),
                   .CHAR_WAIT_CYCLES(3), .CLEAR_WAIT_CYCLES(5)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_value(value[1]), .i_status(status[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_lcd_rs(rs[1]), .o_lcd_rw(rw[1]),
    .o_lcd_en(en[1]), .o_lcd_data(data[1]));

  lcd_hex_writer #(.NIBBLES(1), .MSB_FIRST(1), .EN_HIGH_CYCLES(1),
                   .CHAR_WAIT_CYCLES(0), .CLEAR_WAIT_CYCLES(0)) u_one (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_value(value_one), .i_status(status[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_lcd_rs(rs[2]), .o_lcd_rw(rw[2]),
    .o_lcd_en(en[2]), .o_lcd_data(data[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (prev_en[i] && !en[i] && ev_n[i] < 256) begin
        ev[i][ev_n[i]] = {rs[i], data[i]};
        ev_n[i] = ev_n[i] + 1;
      end
      if (prev_en[i] && en[i] && ({rs[i], data[i]} != prev_bus[i])) unstable[i] = unstable[i] + 1;
      if (busy[i]) busy_cnt[i] = busy_cnt[i] + 1;
      if (done[i]) begin
        done_cnt[i] = done_cnt[i] + 1;
        if (busy[i] || !prev_busy[i]) done_bad[i] = done_bad[i] + 1;
      end
      prev_en[i]   = en[i];
      prev_busy[i] = busy[i];
      prev_bus[i]  = {rs[i], data[i]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int id, input logic [31:0] val, input logic st);
    @(negedge clk);
    if (id == 2) value_one = val[3:0];
    else         value[id] = val;
    status[id] = st;
    start[id]  = 1'b1;
    @(posedge clk);
    #1;
    check("start_busy", 32'(busy[id]), 32'd1);
    check("start_first_byte", {23'd0, rs[id], data[id]}, 32'h001);
    check("start_en_low", 32'(en[id]), 32'd0);
    @(negedge clk);
    start[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    while (!done[id] && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", 32'(done[id]), 32'd1);
  endtask

  task automatic check_events(input int id, input int base, input logic [8:0] e [16], input int n);
    check("event_count", 32'(ev_n[id] - base), 32'(n));
    for (int k = 0; k < n; k++) check("event_byte", {23'd0, ev[id][base + k]}, {23'd0, e[k]});
  endtask

  initial begin
    int b_ev, b_busy, b_done, wait_n;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; status[i] = 1'b0;
      ev_n[i] = 0; busy_cnt[i] = 0; done_cnt[i] = 0; done_bad[i] = 0; unstable[i] = 0;
      prev_en[i] = 1'b0; prev_busy[i] = 1'b0; prev_bus[i] = '0;
    end
    value[0] = '0; value[1] = '0; value_one = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_bus", {22'd0, rs[i], rw[i], en[i], data[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // MSB-first, OK tag
    b_ev = ev_n[0]; b_busy = busy_cnt[0]; b_done = done_cnt[0];
    do_start(0, 32'h1234ABCD, 1'b0);
    wait_done(0);
    repeat (3) @(negedge clk);
    #1;
    check_events(0, b_ev, exp_msb, 13);
    check("msb_busy_cycles", 32'(busy_cnt[0] - b_busy), 32'd93);
    check("msb_done_pulses", 32'(done_cnt[0] - b_done), 32'd1);

    // LSB-first, ER tag
    b_ev = ev_n[1]; b_busy = busy_cnt[1]; b_done = done_cnt[1];
    do_start(1, 32'h0000000F, 1'b1);
    value[1] = 32'h87654321;
    status[1] = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    #1;
    check_events(1, b_ev, exp_lsb, 13);
    check("lsb_busy_cycles", 32'(busy_cnt[1] - b_busy), 32'd93);
    check("lsb_done_pulses", 32'(done_cnt[1] - b_done), 32'd1);

    // single nibble, zero waits
    b_ev = ev_n[2]; b_busy = busy_cnt[2]; b_done = done_cnt[2];
    do_start(2, 32'h9, 1'b0);
    wait_done(2);
    repeat (3) @(negedge clk);
    #1;
    check_events(2, b_ev, exp_one, 6);
    check("one_busy_cycles", 32'(busy_cnt[2] - b_busy), 32'd18);
    check("one_done_pulses", 32'(done_cnt[2] - b_done), 32'd1);

    // start while busy is ignored, then back-to-back start around DONE
    b_ev = ev_n[0]; b_busy = busy_cnt[0]; b_done = done_cnt[0];
    do_start(0, 32'h1234ABCD, 1'b0);
    repeat (8) @(negedge clk);
    value[0] = 32'hFFFFFFFF; status[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (39) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    value[0] = 32'h00C0FFEE; status[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk);
    #1;
    check("done_cycle_start_ignored", 32'(busy[0]), 32'd0);
    check_events(0, b_ev, exp_msb, 13);
    check("busy_run_cycles", 32'(busy_cnt[0] - b_busy), 32'd93);
    check("busy_run_done_pulses", 32'(done_cnt[0] - b_done), 32'd1);
    b_ev = ev_n[0]; b_busy = busy_cnt[0]; b_done = done_cnt[0];
    @(posedge clk);
    #1;
    check("b2b_busy", 32'(busy[0]), 32'd1);
    check("b2b_first_byte", {23'd0, rs[0], data[0]}, 32'h001);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    #1;
    check_events(0, b_ev, exp_b2b, 13);
    check("b2b_busy_cycles", 32'(busy_cnt[0] - b_busy), 32'd93);
    check("b2b_done_pulses", 32'(done_cnt[0] - b_done), 32'd1);

    for (int i = 0; i < 3; i++) begin
      check("bus_stable_while_en", 32'(unstable[i]), 32'd0);
      check("done_after_busy", 32'(done_bad[i]), 32'd0);
    end

    // reset during PULSE of the 4th write
    b_ev = ev_n[0];
    do_start(0, 32'h1234ABCD, 1'b0);
    wait_n = 0;
    while (!((ev_n[0] - b_ev) == 3 && en[0]) && wait_n < 500) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    check("reached_4th_pulse", 32'(en[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_en", 32'(en[0]), 32'd0);
    check("midrst_data", 32'(data[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    check("midrst_rs", 32'(rs[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b_busy = busy_cnt[0]; b_done = done_cnt[0];
    repeat (30) @(negedge clk);
    #1;
    check("post_rst_busy_cycles", 32'(busy_cnt[0] - b_busy), 32'd0);
    check("post_rst_done_pulses", 32'(done_cnt[0] - b_done), 32'd0);
    check("post_rst_bus", {23'd0, en[0], data[0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_hex_writer.md
# lcd_hex_writer

Parametrised HD44780-style LCD writer that renders a captured N-nibble value as upper-case hex, followed by a space and a two-character pass/fail tag. Unlike the single-shot fixed-CRC writer it replaces, it adds:
- a start/busy/done handshake;
- a runtime value and status input;
- programmable enable-pulse and command-settle timing;
- a clear/home preamble;
- selectable digit order.

It sits between the CRC checker and the board LCD pins.

## Interface
- NIBBLES, 8 — hex digits displayed; Value width is 4*NIBBLES; legal range 1..16.
- MSB_FIRST, 1 — 1: most significant nibble printed first; 0: least significant first.
- EN_HIGH_CYCLES, 12 — cycles LCD_EN is held high per write; minimum 1.
- CHAR_WAIT_CYCLES, 2500 — settle cycles after every write except clear; 0 allowed.
- CLEAR_WAIT_CYCLES, 82000 — settle cycles after the clear command; 0 allowed.

- Clock  in  1  — system clock, rising-edge.
- Reset_n  in  1  — asynchronous, active-low reset.
- Start  in  1  — request, sampled only while Busy=0.
- Value  in  4*NIBBLES  — value to display, captured on the accepted Start.
- Status  in  1  — 0 = pass ("OK"), 1 = fail ("ER"), captured with Value.
- Busy  out  1  — sequence in progress.
- Done  out  1  — one-cycle completion pulse.
- LCD_RS  out  1  — 0 = command, 1 = data.
- LCD_RW  out  1  — tied 0 (write only).
- LCD_EN  out  1  — enable strobe.
- LCD_DATA  out  8  — bus byte.

## Operation
- Reset values: LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=8'h00, Busy=0, Done=0, FSM=IDLE, write index=0.
- Reset_n low mid-sequence forces all outputs to their reset values immediately; the sequence is abandoned and not resumed.
- Write list, in order, total NIBBLES+5 writes:
  - 8'h01 (RS=0, clear);
  - 8'h80 (RS=0, DDRAM addr 0);
  - NIBBLES hex chars (RS=1);
  - 8'h20 space (RS=1);
  - tag: "O"(8'h4F), "K"(8'h4B) if Status=0; "E"(8'h45), "R"(8'h52) if Status=1 (RS=1).
- Hex map: 0..9 → 8'h30..8'h39; A..F → 8'h41..8'h46.
- Digit k (k=0..NIBBLES-1) uses Value[4j+3:4j]:
  - MSB_FIRST=1: j = NIBBLES-1-k;
  - MSB_FIRST=0: j = k.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT, DONE.
  - IDLE: Start=1 → capture Value/Status, index=0, go to SETUP.
  - SETUP (1 cycle): RS/DATA driven for the current index, EN=0. → PULSE.
  - PULSE (EN_HIGH_CYCLES cycles): EN=1, RS/DATA stable. → HOLD.
  - HOLD (1 cycle): EN=0, RS/DATA stable. → WAIT.
  - WAIT: EN=0, RS/DATA stable. Duration is CLEAR_WAIT_CYCLES for index 0, otherwise CHAR_WAIT_CYCLES.
    - A count of 0 skips WAIT entirely.
    - At the end of WAIT: if index = NIBBLES+4 → DONE; else index+1 → SETUP.
  - DONE (1 cycle): Done=1, Busy=0. → IDLE.
- Busy=1 in SETUP, PULSE, HOLD and WAIT; otherwise 0.
- Start while Busy=1 is ignored.
- Changes on Value/Status after capture have no effect on the display.
- Wait counters are sized to hold max(CLEAR_WAIT_CYCLES, CHAR_WAIT_CYCLES) with no wrap.
- The write index never exceeds NIBBLES+4.

## Timing
- Start is sampled at edge t0. From t0 onward: Busy=1, the first SETUP is presented, EN=0.
- Period of one write is P = 2 + EN_HIGH_CYCLES + wait, where wait is that write's settle count.
- Busy high for exactly (2+EN_HIGH_CYCLES+CLEAR_WAIT_CYCLES) + (NIBBLES+4)×(2+EN_HIGH_CYCLES+CHAR_WAIT_CYCLES) cycles.
- Done is high in the first cycle after Busy falls, for exactly 1 cycle.
- Start=1 during the DONE cycle is ignored.
- Start sampled in the following IDLE cycle begins a new sequence.
- LCD_DATA/LCD_RS change only in SETUP and never while EN=1. This guarantees ≥1 cycle of setup and ≥1 cycle of hold around each EN pulse.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic MSB-first display:
  - Setup: NIBBLES=8, EN_HIGH=2, CHAR_WAIT=3, CLEAR_WAIT=5; Value=32'h1234ABCD, Status=0; pulse Start.
  - Expected EN-falling-edge bytes: 01,80,31,32,33,34,41,42,43,44,20,4F,4B.
  - RS = 0,0 then 1 for the rest; Busy high exactly 93 cycles; single Done pulse.
- Fail tag, LSB-first:
  - Setup: same timing, MSB_FIRST=0; Value=32'h0000000F, Status=1.
  - Expected bytes after 80: 46,30,30,30,30,30,30,30,20,45,52.
- Start while busy:
  - Stimulus: Start re-asserted at cycles 10 and 50 with a new Value.
  - Expected: output sequence identical to the first run; no extra Done pulse.
- Mid-sequence reset:
  - Stimulus: Reset_n low during the PULSE of the 4th write.
  - Expected: in the same cycle, LCD_EN=0, LCD_DATA=00, Busy=0, Done=0.
  - After release with no Start, outputs stay idle.
- Zero waits, single nibble:
  - Setup: NIBBLES=1, CHAR_WAIT=0, CLEAR_WAIT=0, EN_HIGH=1; Value=4'h9.
  - Expected bytes: 01,80,39,20,4F,4B; Busy high 18 cycles.
- Back-to-back runs:
  - Stimulus: Start asserted in the DONE cycle is ignored; asserted again in the next cycle.
  - Expected: second sequence starts with Busy=1 from that edge.
